regfile_write_arbiter: RTL and testbench

Shares the single write port of mipsregisterfile between two requesters. Requester 0 is ALU writeback: high priority and never buffered. Requester 1 is memory/load writeback: buffered in a small FIFO, with starvation protection. The block drives write_enable/write_register/write_data of the register file from registers, and exports a pending-write mask so decode can stall on buffered load results.

---
 rtl/regfile_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - arbitrates the register-file write port between ALU and load writeback
module regfile_write_arbiter #(
  parameter int MEM_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [4:0]                  alu_register,
  input  logic [31:0]                 alu_data,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [4:0]                  mem_register,
  input  logic [31:0]                 mem_data,
  output logic                        write_enable,
  output logic [4:0]                  write_register,
  output logic [31:0]                 write_data,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(MEM_DEPTH):0]  fifo_count
);

  localparam int CW = $clog2(MEM_DEPTH) + 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  // Load FIFO is kept compacted: slots 0..count_q-1 are live, slot 0 is the head.
  // Squashed entries are removed at the edge, so the head is always a live entry.
  logic [4:0]    ent_reg_q  [MEM_DEPTH];
  logic [4:0]    ent_reg_d  [MEM_DEPTH];
  logic [31:0]   ent_data_q [MEM_DEPTH];
  logic [31:0]   ent_data_d [MEM_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          not_empty;
  logic          override;
  logic          alu_acc;
  logic          pop;
  logic          mem_acc;
  logic          push_keep;
  logic          squash_en;

  // Arbitration: starvation override, then ALU, then FIFO head.
  always_comb begin
    not_empty = (count_q != '0);
    override  = not_empty && (starve_q == SW'(MAX_WAIT));
    alu_acc   = reset && alu_valid && !override;
    pop       = reset && not_empty && (override || !alu_valid);
    mem_ready = reset && (count_q < CW'(MEM_DEPTH));
    mem_acc   = mem_valid && mem_ready;
    squash_en = alu_acc && (alu_register != 5'd0);
    // A load that is older than a same-cycle ALU write to the same register is dead on arrival.
    push_keep = mem_acc && (mem_register != 5'd0) &&
                !(squash_en && (mem_register == alu_register));
  end

  assign alu_ready = alu_acc;

  // Next FIFO contents: drop popped head and squashed entries, compact, then append the push.
  always_comb begin
    int k;
    k = 0;
    for (int j = 0; j < MEM_DEPTH; j++) begin
      ent_reg_d[j]  = '0;
      ent_data_d[j] = '0;
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if ((i < int'(count_q)) && !(pop && (i == 0)) &&
          !(squash_en && (ent_reg_q[i] == alu_register))) begin
        for (int j = 0; j < MEM_DEPTH; j++) begin
          if (j == k) begin
            ent_reg_d[j]  = ent_reg_q[i];
            ent_data_d[j] = ent_data_q[i];
          end
        end
        k = k + 1;
      end
    end
    if (push_keep) begin
      for (int j = 0; j < MEM_DEPTH; j++) begin
        if (j == k) begin
          ent_reg_d[j]  = mem_register;
          ent_data_d[j] = mem_data;
        end
      end
      k = k + 1;
    end
    count_d = CW'(k);
  end

  // Starve counter: counts denied cycles of a waiting head, cleared on pop or when the FIFO drains.
  always_comb begin
    starve_d = '0;
    if (pop || (count_d == '0)) begin
      starve_d = '0;
    end else if (not_empty) begin
      starve_d = (starve_q == SW'(MAX_WAIT)) ? starve_q : starve_q + SW'(1);
    end
  end

  // Winner selection for the registered write port; register 0 grants consume but never write.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (alu_acc) begin
      we_d    = (alu_register != 5'd0);
      wreg_d  = alu_register;
      wdata_d = alu_data;
    end else if (pop) begin
      we_d    = 1'b1;
      wreg_d  = ent_reg_q[0];
      wdata_d = ent_data_q[0];
    end
  end

  // Pending mask reflects the registered live FIFO entries only.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      if (i < int'(count_q)) begin
        pending_mask[ent_reg_q[i]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        ent_reg_q[i]  <= '0;
        ent_data_q[i] <= '0;
      end
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        ent_reg_q[i]  <= ent_reg_d[i];
        ent_data_q[i] <= ent_data_d[i];
      end
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign write_enable   = we_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench with queue-based reference model
module tb_regfile_write_arbiter;

  localparam int MEM_DEPTH = 2;
  localparam int MAX_WAIT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_register;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_register;
  logic [31:0] mem_data;
  logic        write_enable;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending_mask;
  logic [$clog2(MEM_DEPTH):0] fifo_count;

  regfile_write_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_register(alu_register), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_register(mem_register), .mem_data(mem_data),
    .write_enable(write_enable), .write_register(write_register), .write_data(write_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [31:0] rf [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (write_enable === 1'b1 && write_register != 5'd0) rf[write_register] <= write_data;
  end

  // Reference model state.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  logic [31:0] mrf [32] = '{default: 32'd0};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_register = ar; alu_data = ad;
    mem_valid = mv; mem_register = mr; mem_data = md;
  endtask

  // One clock: check comb/state outputs mid-cycle, advance model, check registered outputs after edge.
  task automatic step();
    logic e_ar, e_mr, ne, ovr, rst;
    logic [31:0] e_mask;
    ent_t e;
    @(negedge clk);
    rst = reset;
    ne  = (mq.size() > 0);
    ovr = ne && (m_starve == MAX_WAIT);
    e_ar = rst && alu_valid && !ovr;
    e_mr = rst && (mq.size() < MEM_DEPTH);
    e_mask = '0;
    foreach (mq[i]) e_mask[mq[i].r] = 1'b1;
    check("alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
    check("mem_ready", {31'd0, mem_ready}, {31'd0, e_mr});
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("pending_mask", pending_mask, e_mask);

    if (m_we && m_reg != 5'd0) mrf[m_reg] = m_data;

    if (!rst) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0; m_reg = '0; m_data = '0;
    end else begin
      logic popped;
      popped = 1'b0;
      if (e_ar) begin
        m_we = (alu_register != 5'd0);
        m_reg = alu_register; m_data = alu_data;
        if (alu_register != 5'd0)
          for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == alu_register) mq.delete(i);
      end else if (ne) begin
        e = mq.pop_front();
        popped = 1'b1;
        m_we = 1'b1; m_reg = e.r; m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (mem_valid && e_mr && mem_register != 5'd0 && !(e_ar && mem_register == alu_register))
        mq.push_back('{r: mem_register, d: mem_data});
      if (popped || mq.size() == 0) m_starve = 0;
      else if (ne) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      else m_starve = 0;
    end

    @(posedge clk);
    #1;
    check("write_enable", {31'd0, write_enable}, {31'd0, m_we});
    if (m_we) begin
      check("write_register", {27'd0, write_register}, {27'd0, m_reg});
      check("write_data", write_data, m_data);
    end
    if (!rst) begin
      check("rst_write_register", {27'd0, write_register}, 32'd0);
      check("rst_write_data", write_data, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;

    // Reset held two cycles with requests asserted.
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd3, 32'h2);
    step();
    step();
    reset = 1'b1;

    // ALU path r5 = 10.
    drive(1'b1, 5'd5, 32'h0000000A, 1'b0, 5'd0, 32'd0);
    step();
    check("alu_latency_we", {31'd0, write_enable}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("rf_r5", rf[5], 32'd10);

    // Load fill under continuous ALU traffic, then starvation override.
    drive(1'b1, 5'd7, 32'd100, 1'b1, 5'd2, 32'd12);
    step();
    drive(1'b1, 5'd7, 32'd101, 1'b1, 5'd3, 32'd13);
    step();
    drive(1'b1, 5'd7, 32'd102, 1'b0, 5'd0, 32'd0);
    check("fill_count", 32'(fifo_count), 32'd2);
    check("fill_mask", pending_mask, 32'h0000000C);
    for (int i = 0; i < 12; i++) begin
      alu_data = 32'd200 + 32'(i);
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("rf_r2", rf[2], 32'd12);
    check("rf_r3", rf[3], 32'd13);

    // Squash: buffered r28=50 killed by ALU r28=25.
    drive(1'b1, 5'd9, 32'd1, 1'b1, 5'd28, 32'd50);
    step();
    drive(1'b1, 5'd28, 32'd25, 1'b0, 5'd0, 32'd0);
    step();
    check("squash_count", 32'(fifo_count), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("rf_r28", rf[28], 32'd25);

    // Register 0 traffic.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd20);
    step();
    check("r0_load_count", 32'(fifo_count), 32'd0);
    drive(1'b1, 5'd0, 32'd20, 1'b0, 5'd0, 32'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("rf_r0", rf[0], 32'd0);

    // Mid-operation reset discards a full FIFO.
    drive(1'b1, 5'd9, 32'd3, 1'b1, 5'd4, 32'd10);
    step();
    drive(1'b1, 5'd9, 32'd4, 1'b1, 5'd31, 32'd10);
    step();
    check("midrst_full", 32'(fifo_count), 32'd2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_mask", pending_mask, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("rf_r4", rf[4], 32'd0);
    check("rf_r31", rf[31], 32'd0);

    // Randomized traffic on a small register set to provoke squashes and overrides.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      drive($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom());
      step();
    end
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 6; i++) step();
    for (int r = 0; r < 32; r++) check($sformatf("final_rf_r%0d", r), rf[r], mrf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
